sequence_decode_unit: RTL



---
 rtl/basic_computer_pkg.sv | 29 ++
 rtl/sequence_decode_unit_if.sv | 61 ++++++
 rtl/onehot_dec.sv | 16 +
 rtl/sequence_decode_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/basic_computer_pkg.sv
// Shared Basic Computer definitions: opcode encoding, IR field layout,
// and the default sequence-counter width.
package basic_computer_pkg;

    localparam int unsigned IR_W         = 16;
    localparam int unsigned OPCODE_W     = 3;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned SC_WIDTH_DEF = 4;

    // Memory-reference opcodes per IR[14:12]; 7 selects register/IO group
    typedef enum logic [OPCODE_W-1:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_IO  = 3'd7
    } opcode_e;

    // Instruction word layout: I bit, opcode, address
    typedef struct packed {
        logic                i;
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   addr;
    } ir_t;

endpackage

// File: rtl/sequence_decode_unit_if.sv
// Control interface between the control unit (master: issues SC/IR/flag
// commands, observes timing/decode/flags) and the sequence decode unit
// (slave: obeys commands, drives timing/decode/flag state).
interface sequence_decode_unit_if
    import basic_computer_pkg::*;
#(
    parameter int unsigned SC_WIDTH = SC_WIDTH_DEF
);
    localparam int unsigned T_W = 1 << SC_WIDTH;

    // Commands from the control unit / devices
    logic [IR_W-1:0] Bus;
    logic            LD_IR;
    logic            CLR_SC;
    logic            INR_SC;
    logic            Set_S;
    logic            Clear_S;
    logic            Set_R;
    logic            Clear_R;
    logic            Set_IEN;
    logic            Clear_IEN;
    logic            Clear_E;
    logic            Comp_E;
    logic            E_Load;
    logic            E_In;
    logic            Clear_FGI;
    logic            Set_FGO;
    logic            In_Strobe;
    logic            Out_Take;

    // Timing, decode and flag state
    logic [SC_WIDTH-1:0]     SC;
    logic [T_W-1:0]          T;
    logic [IR_W-1:0]         IR;
    logic [(1<<OPCODE_W)-1:0] D;
    logic                    I;
    logic [ADDR_W-1:0]       B;
    logic                    S;
    logic                    R;
    logic                    E;
    logic                    IEN;
    logic                    FGI;
    logic                    FGO;

    modport master (
        output Bus, LD_IR, CLR_SC, INR_SC,
               Set_S, Clear_S, Set_R, Clear_R, Set_IEN, Clear_IEN,
               Clear_E, Comp_E, E_Load, E_In,
               Clear_FGI, Set_FGO, In_Strobe, Out_Take,
        input  SC, T, IR, D, I, B, S, R, E, IEN, FGI, FGO
    );

    modport slave (
        input  Bus, LD_IR, CLR_SC, INR_SC,
               Set_S, Clear_S, Set_R, Clear_R, Set_IEN, Clear_IEN,
               Clear_E, Comp_E, E_Load, E_In,
               Clear_FGI, Set_FGO, In_Strobe, Out_Take,
        output SC, T, IR, D, I, B, S, R, E, IEN, FGI, FGO
    );

endinterface

// File: rtl/onehot_dec.sv
// N-bit binary to 2**N one-hot decoder (purely combinational).
//   in_val     : binary index
//   out_onehot : bit in_val set, all others clear
module onehot_dec #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]        in_val,
    output logic [(1<<N)-1:0]   out_onehot
);

    always_comb begin
        out_onehot         = '0;
        out_onehot[in_val] = 1'b1;
    end

endmodule

// File: rtl/sequence_decode_unit.sv
// Timing and decode front-end for the Basic Computer control unit.
// Owns SC, IR and the S/R/E/IEN/FGI/FGO flags; produces one-hot T from SC
// and one-hot D plus I/B fields from IR.
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus_if  : slave side of the control interface (commands in, state out)
module sequence_decode_unit
    import basic_computer_pkg::*;
#(
    parameter int unsigned SC_WIDTH = SC_WIDTH_DEF,
    parameter bit          FGO_RST  = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    sequence_decode_unit_if.slave         bus_if
);

    localparam int unsigned T_W = 1 << SC_WIDTH;
    localparam int unsigned D_W = 1 << OPCODE_W;

    logic [SC_WIDTH-1:0] sc_q, sc_d;
    ir_t                 ir_q, ir_d;
    logic                s_q, s_d;
    logic                r_q, r_d;
    logic                e_q, e_d;
    logic                ien_q, ien_d;
    logic                fgi_q, fgi_d;
    logic                fgo_q, fgo_d;

    opcode_e             opcode_c;
    logic [T_W-1:0]      t_c;
    logic [D_W-1:0]      d_c;

    // Next-state: SC, IR and flag priorities
    always_comb begin
        sc_d  = sc_q;
        ir_d  = ir_q;
        s_d   = s_q;
        r_d   = r_q;
        e_d   = e_q;
        ien_d = ien_q;
        fgi_d = fgi_q;
        fgo_d = fgo_q;

        // Clear wins; increment is gated by S so a halted machine freezes
        if (bus_if.CLR_SC) begin
            sc_d = '0;
        end else if (bus_if.INR_SC && s_q) begin
            sc_d = sc_q + SC_WIDTH'(1);
        end

        if (bus_if.LD_IR) begin
            ir_d = ir_t'(bus_if.Bus);
        end

        if (bus_if.Clear_S)      s_d = 1'b0;
        else if (bus_if.Set_S)   s_d = 1'b1;

        if (bus_if.Clear_R)      r_d = 1'b0;
        else if (bus_if.Set_R)   r_d = 1'b1;

        if (bus_if.Clear_IEN)    ien_d = 1'b0;
        else if (bus_if.Set_IEN) ien_d = 1'b1;

        if (bus_if.Clear_E)      e_d = 1'b0;
        else if (bus_if.Comp_E)  e_d = ~e_q;
        else if (bus_if.E_Load)  e_d = bus_if.E_In;

        if (bus_if.Clear_FGI)      fgi_d = 1'b0;
        else if (bus_if.In_Strobe) fgi_d = 1'b1;

        // Device readiness: the CPU re-arming FGO beats the device taking it
        if (bus_if.Set_FGO)       fgo_d = 1'b1;
        else if (bus_if.Out_Take) fgo_d = 1'b0;
    end

    // State registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sc_q  <= '0;
            ir_q  <= '0;
            s_q   <= 1'b1;
            r_q   <= 1'b0;
            e_q   <= 1'b0;
            ien_q <= 1'b0;
            fgi_q <= 1'b0;
            fgo_q <= FGO_RST;
        end else begin
            sc_q  <= sc_d;
            ir_q  <= ir_d;
            s_q   <= s_d;
            r_q   <= r_d;
            e_q   <= e_d;
            ien_q <= ien_d;
            fgi_q <= fgi_d;
            fgo_q <= fgo_d;
        end
    end

    assign opcode_c = opcode_e'(ir_q.opcode);

    // Timing decode SC -> T
    onehot_dec #(.N(SC_WIDTH)) u_t_dec (
        .in_val     (sc_q),
        .out_onehot (t_c)
    );

    // Opcode decode IR[14:12] -> D
    onehot_dec #(.N(OPCODE_W)) u_d_dec (
        .in_val     (opcode_c),
        .out_onehot (d_c)
    );

    assign bus_if.SC  = sc_q;
    assign bus_if.T   = t_c;
    assign bus_if.IR  = ir_q;
    assign bus_if.D   = d_c;
    assign bus_if.I   = ir_q.i;
    assign bus_if.B   = ir_q.addr;
    assign bus_if.S   = s_q;
    assign bus_if.R   = r_q;
    assign bus_if.E   = e_q;
    assign bus_if.IEN = ien_q;
    assign bus_if.FGI = fgi_q;
    assign bus_if.FGO = fgo_q;

endmodule
